irrigation_scheduler: RTL
=========================

// Module: irrigation_scheduler
// PURPOSE
//  Sequences a two-area irrigation system that shares one pump.
//  Debounces the two soil-humidity sensors U[1:0] (1 = area dry) and grants the pump to one area at a time, round-robin.
//  Per grant it opens the valve, primes, waters, then cools down.
//  Drives the 7-segment humidity indicator (dark/0/1/2) from the debounced demand.
// PARAMETERS
//  DEB_CYCLES    4   consecutive equal samples needed before a sensor change is accepted
//  PRIME_CYCLES  2   cycles the valve is open with the pump off before watering starts
//  MAX_ON        16  maximum pump-on cycles per grant; reaching it flags a fault
//  GAP_CYCLES    3   pump/valve-off cycles after each grant before the next grant
// PORTS
//  clk        in   1  single clock; everything is on its rising edge
//  reset      in   1  synchronous, active-high reset
//  U          in   2  raw sensors; U[i]=1 means area i has low humidity
//  clr_fault  in   1  one-cycle pulse; clears both fault bits
//  valve      out  2  valve[i]=1 means area i valve is open
//  pump       out  1  pump on
//  busy       out  1  1 in any state except IDLE
//  fault      out  2  fault[i]=1 means area i hit MAX_ON without drying
//  {a,b,c,d,e,f,g}  out  1 each  segment drives, active-high
// BEHAVIOUR
//  Reset
//   - All outputs are 0 on the first edge with reset=1, including mid-grant.
//   - State=IDLE, dem=00, debounce counters=0, cnt=0, last=1 (so area 0 wins the first tie).
//  Debounce (per area i)
//   - If U[i]!=dem[i], deb_cnt[i] increments; otherwise it clears.
//   - When deb_cnt[i]==DEB_CYCLES-1 and U[i]!=dem[i], dem[i]<=U[i] and deb_cnt[i]<=0.
//   - Net effect: a stable change shows on dem DEB_CYCLES edges after it first appears.
//  Eligibility: elig[i] = dem[i] & ~fault[i]
//  FSM (cnt is a shared counter, cleared on every state entry)
//   - IDLE
//       - if elig==00, stay.
//       - else pick cur: the only eligible area, or ~last if both are eligible.
//       - go to PRIME; valve[cur]<=1 on the same edge.
//   - PRIME
//       - valve[cur]=1, pump=0.
//       - when cnt==PRIME_CYCLES-1, go to WATER and pump<=1.
//   - WATER
//       - if dem[cur]==0, go to COOLDOWN; pump and valve go to 0 on that edge.
//       - else if cnt==MAX_ON-1, set fault[cur]<=1 and go to COOLDOWN the same way.
//       - dem has priority over timeout when both happen in the same cycle: no fault is set.
//       - last<=cur on exit.
//   - COOLDOWN
//       - all valves and the pump stay 0.
//       - when cnt==GAP_CYCLES-1, go to IDLE.
//   - Grant latency: an eligible demand in IDLE gives valve=1 on the next edge and pump=1 PRIME_CYCLES edges later.
//  Mid-grant events
//   - Demand from the other area does not preempt the current grant; it is served after COOLDOWN.
//   - If dem[cur] drops during PRIME, PRIME still completes; WATER then exits on its first cycle (pump on 1 cycle).
//  Fault
//   - fault[i] clears when clr_fault=1 or when dem[i]==0.
//   - Clearing has priority over a same-cycle set on the other bit only; a same-cycle set on the same bit wins over clr_fault.
//  Invariants
//   - valve is never 11.
//   - pump=1 implies valve!=00.
//   - busy=0 implies valve==00 and pump==0.
//  Display: combinational from the registered dem, so it reads all-0 in reset
//   - 00 -> 0000000 (dark)
//   - 01 -> 1111110 ('0')
//   - 10 -> 0110000 ('1')
//   - 11 -> 1101101 ('2')
//  Widths
//   - cnt is $clog2(max(PRIME_CYCLES,MAX_ON,GAP_CYCLES)) bits.
//   - deb_cnt is $clog2(DEB_CYCLES)+1 bits.
//   - No counter wraps, because every state exits at its terminal count.
// STRUCTURE
//  irrigation_pkg holds:
//   - typedef enum logic[1:0] {IDLE,PRIME,WATER,COOLDOWN} irr_state_t
//   - localparam logic[6:0] SEG_BLANK, SEG_0, SEG_1, SEG_2
//  One sub-module, humidity_debouncer:
//   - one instance per area, parameter DEB_CYCLES
//   - ports clk, reset, raw, clean
//  FSM, round-robin pointer, fault logic and display decode live in this module.
// TESTING
//  1. Reset: hold reset with U=11 -> all outputs 0. After release, dem=11 at edge 4.
//     Then valve=01 at edge 5, pump=1 at edge 7, display shows '2'.
//  2. Debounce: U[0] pulses 1 for 3 cycles -> dem stays 00 and valve stays 00.
//     A 4-cycle pulse -> dem[0]=1 and a grant follows.
//  3. Round-robin: U=11 steady; area 0 is served. Drop U[0] during WATER.
//     -> valve 01 -> 00, then 3 COOLDOWN cycles, then valve=10.
//  4. Timeout: U=01 steady -> pump on for exactly 16 cycles, then fault=01 and valve=00.
//     Area 0 is not re-granted; clr_fault re-arms it.
//  5. Reset mid-WATER with pump=1 -> valve=00, pump=0, busy=0 and display dark on the next edge.
//  6. Assertions run for the whole bench: the three invariants above, plus
//     no grant to a faulted area.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the two-area irrigation scheduler.
package irrigation_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      WATER,
      COOLDOWN
   } irr_state_t;

   // Segment patterns ordered {a,b,c,d,e,f,g}, active-high
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;

   function automatic int max3(input int x, input int y, input int z);
      int m;
      m = (x > y) ? x : y;
      return (m > z) ? m : z;
   endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Sensor/command inputs and actuator/display outputs of the scheduler.
interface irrigation_scheduler_if;
   logic [1:0] U;
   logic       clr_fault;
   logic [1:0] valve;
   logic       pump;
   logic       busy;
   logic [1:0] fault;
   logic       a, b, c, d, e, f, g;

   // Controller side
   modport slave (
      input  U, clr_fault,
      output valve, pump, busy, fault, a, b, c, d, e, f, g
   );

   // Environment side
   modport master (
      output U, clr_fault,
      input  valve, pump, busy, fault, a, b, c, d, e, f, g
   );
endinterface

// File: rtl/irrigation_scheduler_humidity_debouncer.sv
// Accepts a raw sensor change only after DEB_CYCLES consecutive differing samples.
module humidity_debouncer #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean
);

   localparam int W = $clog2(DEB_CYCLES) + 1;

   logic [W-1:0] cnt_q, cnt_d;
   logic         clean_q, clean_d;

   // Count run length of disagreement; commit at the terminal count
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      if (raw != clean_q) begin
         if (cnt_q == W'(DEB_CYCLES - 1)) begin
            clean_d = raw;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   assign clean = clean_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// Two-area irrigation scheduler: debounced demand, round-robin pump grant,
// prime/water/cooldown sequencing, timeout fault and humidity display.
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int PRIME_CYCLES = 2,
   parameter int MAX_ON       = 16,
   parameter int GAP_CYCLES   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   irrigation_scheduler_if.slave   bus
);

   localparam int CNT_MAX = max3(PRIME_CYCLES, MAX_ON, GAP_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(MAX_ON - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   logic [1:0]       dem;
   logic [1:0]       elig;
   irr_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cur_q, cur_d;
   logic             last_q, last_d;
   logic [1:0]       valve_q, valve_d;
   logic             pump_q, pump_d;
   logic [1:0]       fault_q, fault_d;
   logic [1:0]       fault_set;
   logic [1:0]       fault_clr;
   logic [6:0]       seg;

   for (genvar i = 0; i < 2; i++) begin : g_deb
      humidity_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (bus.U[i]),
         .clean (dem[i])
      );
   end

   assign elig = dem & ~fault_q;

   // Next-state, actuator and fault-set decisions
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      cur_d     = cur_q;
      last_d    = last_q;
      valve_d   = valve_q;
      pump_d    = pump_q;
      fault_set = '0;

      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            valve_d = '0;
            pump_d  = 1'b0;
            if (elig != 2'b00) begin
               cur_d   = (elig == 2'b11) ? ~last_q : elig[1];
               state_d = PRIME;
               valve_d = cur_d ? 2'b10 : 2'b01;
            end
         end
         PRIME: begin
            pump_d = 1'b0;
            if (cnt_q == PRIME_LAST) begin
               state_d = WATER;
               cnt_d   = '0;
               pump_d  = 1'b1;
            end
         end
         WATER: begin
            // Demand drop is checked first so a coincident timeout sets no fault
            if (!dem[cur_q] || (cnt_q == ON_LAST)) begin
               if (dem[cur_q]) begin
                  fault_set[cur_q] = 1'b1;
               end
               state_d = COOLDOWN;
               cnt_d   = '0;
               valve_d = '0;
               pump_d  = 1'b0;
               last_d  = cur_q;
            end
         end
         COOLDOWN: begin
            valve_d = '0;
            pump_d  = 1'b0;
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            valve_d = '0;
            pump_d  = 1'b0;
         end
      endcase

      // A set on a bit beats any clear of that same bit
      fault_clr = {2{bus.clr_fault}} | ~dem;
      fault_d   = fault_set | (fault_q & ~fault_clr);
   end

   // Controller registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cur_q   <= 1'b0;
         last_q  <= 1'b1;
         valve_q <= '0;
         pump_q  <= 1'b0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         valve_q <= valve_d;
         pump_q  <= pump_d;
         fault_q <= fault_d;
      end
   end

   // Humidity indicator decoded from registered demand
   always_comb begin
      case (dem)
         2'b01:   seg = SEG_0;
         2'b10:   seg = SEG_1;
         2'b11:   seg = SEG_2;
         default: seg = SEG_BLANK;
      endcase
   end

   assign bus.valve = valve_q;
   assign bus.pump  = pump_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.fault = fault_q;
   assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg;

endmodule
